// File: rtl/mem_arbiter.sv
// Cache-bus memory responder: arbitrates icache/dcache requests onto one RAM port.
// Optional macro ARB_RR_EN switches fixed data-first priority to round-robin.
module mem_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_WORD       = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, IREAD, DREAD, DWRITE} state_t;

  localparam logic [1:0]       ST_ACCESS = 2'd2;
  localparam logic [1:0]       ST_ERROR  = 2'd3;
  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] count;
  logic [31:0]      addr_p1;
  logic [31:0]      store_p1;
  logic             grant_i, grant_dr, grant_dw;
  logic             held, done, fail;

`ifdef ARB_RR_EN
  // Set after a data transaction ends, so instruction fetch goes first next time.
  logic i_turn;
  always_comb grant_i = iREN && (i_turn || !(dREN || dWEN));
`else
  always_comb grant_i = iREN && !dREN && !dWEN;
`endif

  always_comb begin
    grant_dw = dWEN && !grant_i;
    grant_dr = dREN && !dWEN && !grant_i;
  end

  // Withdrawal wins over any RAM response in the same cycle.
  always_comb begin
    held = 1'b0;
    case (state)
      IREAD:   held = iREN;
      DREAD:   held = dREN;
      DWRITE:  held = dWEN;
      default: held = 1'b0;
    endcase
    done = held && (ramstate == ST_ACCESS);
    fail = held && !done && ((ramstate == ST_ERROR) || (count == CNT_LAST));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_dw)      next_state = DWRITE;
        else if (grant_dr) next_state = DREAD;
        else if (grant_i)  next_state = IREAD;
      end
      default: begin
        if (!held || done || fail) next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    err      = fail;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IREAD: begin
        ramREN  = 1'b1;
        ramaddr = addr_p1;
        if (done) begin
          iwait = 1'b0;
          iload = ramload;
        end else if (fail) begin
          iwait = 1'b0;
          iload = ERR_WORD;
        end
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = addr_p1;
        if (done) begin
          dwait = 1'b0;
          dload = ramload;
        end else if (fail) begin
          dwait = 1'b0;
          dload = ERR_WORD;
        end
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = addr_p1;
        ramstore = store_p1;
        if (done || fail) begin
          dwait = 1'b0;
          dload = fail ? ERR_WORD : '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE) count <= '0;
      else               count <= count + 1'b1;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge CLK) begin
    if (RST)               i_turn <= 1'b0;
    else if (done || fail) i_turn <= (state != IREAD);
  end
`endif

  // Grant stage: capture the winner's address/data so later bus changes are ignored.
  always_ff @(posedge CLK) begin
    if (state == IDLE) begin
      if (grant_i)                  addr_p1 <= iaddr;
      else if (grant_dr || grant_dw) addr_p1 <= daddr;
      if (grant_dw)                 store_p1 <= dstore;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (default build: fixed data-first priority).
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_i;
    logic [31:0] load;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic is_i, input logic [31:0] load, input logic e_err);
    exp_t x;
    x.is_i = is_i;
    x.load = load;
    x.err  = e_err;
    sb.push_back(x);
  endtask

  // Completion monitor: every wait pulse must match the next scoreboard entry.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (!iwait || !dwait) begin
        if (sb.size() == 0) begin
          check("spurious_cpl", {iwait, dwait}, 2'b11);
        end else begin
          e = sb.pop_front();
          check("cpl_port", {iwait, dwait}, e.is_i ? 2'b01 : 2'b10);
          check("cpl_load", e.is_i ? iload : dload, e.load);
          check("cpl_err", err, e.err);
          check("cpl_other_load", e.is_i ? dload : iload, 0);
        end
      end else begin
        check("quiet_outs", {err, iload, dload}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    step(); step();
    @(negedge CLK);
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_err", err, 0);
    step();
    RST = 1'b0;
    mon_en = 1'b1;

    // Fetch with one-cycle latency
    iREN = 1; iaddr = 32'h40;
    push(1'b1, 32'h8C220004, 1'b0);
    @(negedge CLK);
    check("fetch_c0_ramREN", ramREN, 0);
    step();
    ramstate = ACCESS; ramload = 32'h8C220004;
    @(negedge CLK);
    check("fetch_c1_ramREN", ramREN, 1);
    check("fetch_c1_ramWEN", ramWEN, 0);
    check("fetch_c1_ramaddr", ramaddr, 32'h40);
    step();
    iREN = 0; ramstate = FREE;
    @(negedge CLK);
    check("fetch_c2_ramREN", ramREN, 0);
    check("fetch_c2_ramWEN", ramWEN, 0);

    // Contention: write, then read, then fetch
    step();
    iREN = 1; iaddr = 32'h80; dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    ramstate = ACCESS; ramload = 32'h5555AAAA;
    push(1'b0, 32'h0, 1'b0);
    push(1'b0, 32'h5555AAAA, 1'b0);
    push(1'b1, 32'h5555AAAA, 1'b0);
    step();
    @(negedge CLK);
    check("cont_w_ramWEN", ramWEN, 1);
    check("cont_w_ramREN", ramREN, 0);
    check("cont_w_ramaddr", ramaddr, 32'h100);
    check("cont_w_ramstore", ramstore, 32'hDEADBEEF);
    step();
    dWEN = 0; daddr = 32'h999; dstore = 32'h0;
    @(negedge CLK);
    check("cont_gap1_strobes", {ramREN, ramWEN}, 2'b00);
    check("cont_gap1_ramaddr", ramaddr, 0);
    step();
    daddr = 32'h104;
    @(negedge CLK);
    check("cont_r_ramREN", {ramREN, ramWEN}, 2'b10);
    check("cont_r_ramaddr", ramaddr, 32'h999);
    step();
    dREN = 0;
    @(negedge CLK);
    check("cont_gap2_strobes", {ramREN, ramWEN}, 2'b00);
    step();
    iaddr = 32'h84;
    @(negedge CLK);
    check("cont_i_ramREN", {ramREN, ramWEN}, 2'b10);
    check("cont_i_ramaddr", ramaddr, 32'h80);
    step();
    iREN = 0; ramstate = FREE;

    // RAM stall: three BUSY cycles, ACCESS in the fourth
    step();
    dREN = 1; daddr = 32'h200; ramstate = BUSY;
    push(1'b0, 32'h1234, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      @(negedge CLK);
      check("stall_dwait", dwait, 1);
    end
    step();
    ramstate = ACCESS; ramload = 32'h1234;
    @(negedge CLK);
    check("stall_c4_dwait", dwait, 0);
    step();
    dREN = 0; ramstate = FREE;

    // RAM ERROR during a read
    step();
    dREN = 1; daddr = 32'h300;
    push(1'b0, 32'hBAD1BAD1, 1'b1);
    step();
    ramstate = ERROR;
    @(negedge CLK);
    check("error_err", err, 1);
    step();
    dREN = 0; ramstate = FREE;

    // Timeout with RAM held BUSY
    step();
    dREN = 1; daddr = 32'h304; ramstate = BUSY;
    push(1'b0, 32'hBAD1BAD1, 1'b1);
    step();
    n = 0;
    for (int k = 1; k <= 100 && n == 0; k++) begin
      @(negedge CLK);
      if (!dwait) n = k;
      else step();
    end
    check("timeout_cycle", n, 64);
    step();
    dREN = 0; ramstate = FREE;

    // Reset in the middle of a fetch
    step();
    iREN = 1; iaddr = 32'h500; ramstate = BUSY;
    step();
    @(negedge CLK);
    check("rstmid_ramREN_before", ramREN, 1);
    step();
    RST = 1;
    step();
    @(negedge CLK);
    check("rstmid_ramREN", ramREN, 0);
    check("rstmid_iwait", iwait, 1);
    step();
    RST = 0; iREN = 0; ramstate = FREE;

    // Withdrawal of a read in service
    step();
    dREN = 1; daddr = 32'h600; ramstate = BUSY;
    step();
    step();
    dREN = 0;
    @(negedge CLK);
    check("wd_dwait_same", dwait, 1);
    step();
    @(negedge CLK);
    check("wd_ramREN", ramREN, 0);
    check("wd_dwait", dwait, 1);
    check("wd_err", err, 0);
    step();
    ramstate = FREE;
    step();

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
